l2spm_arbiter: RTL and testbench
================================

# l2spm_arbiter

Shares the single-port 64 KiB L2 scratchpad among `NumReq` bus-side requesters (debug, CVA6, cluster, DMA) with round-robin arbitration. It grants at most one access per cycle and checks the address against the L2SPM window. It routes each one-cycle-latency SRAM response back to the granted requester. Sits between the crossbar's L2SPM slave adapters and the SRAM macro wrapper.

## Interface
- `NumReq`, 4, number of requesters (= `ariane_soc::NrSlaves`)
- `AddrWidth`, 64, requester address width
- `DataWidth`, 64, data width; `BeWidth = DataWidth/8`
- `BaseAddr`, `ariane_soc::L2SPMBase` (0x1C00_0000), window start
- `Length`, `ariane_soc::L2SPMLength` (0x10000), window size in bytes
- `MemAddrWidth`, `$clog2(Length/BeWidth)` = 13, SRAM word address width

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_i`  in  NumReq  request valid per requester
- `addr_i`  in  NumReq×AddrWidth  byte address
- `we_i`  in  NumReq  1 = write
- `be_i`  in  NumReq×BeWidth  byte enables
- `wdata_i`  in  NumReq×DataWidth  write data
- `gnt_o`  out  NumReq  one-hot grant, same cycle as accepted request
- `rvalid_o`  out  NumReq  response valid (reads and writes)
- `err_o`  out  NumReq  response is an address error, qualified by rvalid_o
- `rdata_o`  out  NumReq×DataWidth  read data, qualified by rvalid_o
- `mem_req_o`  out  1  SRAM access
- `mem_gnt_i`  in  1  SRAM ready; 0 = busy (scrub/init)
- `mem_we_o`, `mem_be_o`, `mem_wdata_o`  out  1/BeWidth/DataWidth  SRAM write controls
- `mem_addr_o`  out  MemAddrWidth  word address = `(addr - BaseAddr) >> $clog2(BeWidth)`
- `mem_rdata_i`  in  DataWidth  valid the cycle after `mem_req_o && mem_gnt_i`

## Operation
- Arbitration: a requester is eligible when `req_i[i]` is high. Priority starts at pointer `ptr` and goes `ptr, ptr+1, …` mod NumReq. The lowest-distance eligible requester wins.
- A grant is issued only when `mem_gnt_i` is high and `rst_i` is low. When `mem_gnt_i` is low, `gnt_o` = 0 and `ptr` holds.
- After a grant to i, `ptr` ← (i+1) mod NumReq. With no grant, `ptr` holds.
- Requesters hold `req_i` and their payload stable until granted. Dropping `req_i` before the grant is allowed; the request is simply not served.
- Range check on the winner: in range iff `BaseAddr ≤ addr < BaseAddr+Length` (full AddrWidth compare, no wrap).
  - In range: `mem_req_o` = 1 and the payload is muxed to the mem_* ports.
  - Out of range: granted, but `mem_req_o` = 0 and an error response is queued.
- Response stage registers: `resp_valid_q`, `resp_idx_q` (clog2 NumReq), `resp_err_q`.
  - Next cycle: `rvalid_o[resp_idx_q]` = 1 and `err_o[resp_idx_q]` = resp_err_q.
  - `rdata_o[resp_idx_q]` = `mem_rdata_i` for an in-range read; 0 for a write or an error.
  - All other rdata_o lanes are 0.
- Reset: `ptr` = 0, resp_* = 0. While rst_i is high, all outputs are 0. A response pending when reset asserts is dropped.

## Timing
- Grant is combinational from `req_i`/`mem_gnt_i` (same cycle).
- Response latency is exactly 1 cycle after the grant. Throughput is 1 access/cycle; back-to-back grants are allowed, including to the same requester when it is the only one requesting.
- A response at cycle t+1 and a new grant at t+1 coexist without conflict.
- No combinational path from `mem_rdata_i` to `gnt_o`.

## Structure
- Window constants come from the existing `ariane_soc` package (`L2SPMBase`, `L2SPMLength`, `NrSlaves`).
- Add an `l2spm_req_t` struct (addr, we, be, wdata) to `ariane_soc` so the crossbar adapters share it.
- Sub-module `l2spm_rr_arbiter`: parameterised round-robin pointer and one-hot grant logic, with `en_i` = mem_gnt_i. The top level holds the mux, range check and response stage.

## Test plan
- Reset then single read: req_i=0001, addr=0x1C00_0008, mem_rdata=0xDEAD_BEEF → gnt_o=0001, mem_addr_o=1, next cycle rvalid_o=0001, rdata_o[0]=0xDEAD_BEEF, err_o=0.
- Contention: req_i=1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3, one grant per cycle, rvalid follows by 1 cycle.
- Out of range: requester 2 writes addr 0x1C01_0000 → gnt_o=0100, mem_req_o=0, next cycle rvalid_o[2]=1, err_o[2]=1, rdata_o[2]=0. Repeat with 0x1BFF_FFF8.
- Memory busy: mem_gnt_i=0 for 3 cycles with req_i=0011 → no grants, ptr unchanged; on mem_gnt_i=1, requester 0 is granted first when ptr=0.
- Reset mid-op: grant at t, rst_i=1 at t+1 → rvalid_o=0 at t+1. After release, req_i=1000 and 0001 together → requester 0 wins (ptr=0).
- Write byte enables: requester 1 writes be=0x0F, wdata=0x1122_3344_5566_7788 at 0x1C00_FFF8 → mem_addr_o=0x1FFF, mem_be_o=0x0F, next cycle rvalid_o[1]=1, rdata_o[1]=0.

Source files
------------

// File: rtl/l2spm_arbiter_pkg.sv
// Shared types and window constants for the L2 scratchpad access path.
// The window constants and the request payload mirror the ariane_soc SoC
// definitions (NrSlaves, L2SPMBase, L2SPMLength) so that the crossbar
// L2SPM adapters and this arbiter agree on one payload layout.
package l2spm_arbiter_pkg;

  // Number of bus-side requesters: debug, CVA6, cluster, DMA.
  localparam int unsigned NrSlaves    = 4;

  // L2 scratchpad window in the system address map.
  localparam logic [63:0] L2SPMBase   = 64'h0000_0000_1C00_0000;
  localparam int unsigned L2SPMLength = 32'h0001_0000;

  // Bus widths used by the shared request payload.
  localparam int unsigned L2AddrWidth = 64;
  localparam int unsigned L2DataWidth = 64;
  localparam int unsigned L2BeWidth   = L2DataWidth / 8;

  // Request payload presented by each crossbar adapter.
  typedef struct packed {
    logic [L2AddrWidth-1:0] addr;
    logic                   we;
    logic [L2BeWidth-1:0]   be;
    logic [L2DataWidth-1:0] wdata;
  } l2spm_req_t;

endpackage : l2spm_arbiter_pkg

// File: rtl/l2spm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NumReq requesters, search starts
// at a rotating pointer that moves just past the most recent winner.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (pointer back to 0)
//   en_i     grant enable; when low no grant is issued and the pointer holds
//   req_i    request per requester
//   gnt_o    one-hot grant (combinational)
//   idx_o    index of the winner (meaningful when valid_o is high)
//   valid_o  a grant is issued this cycle
module l2spm_rr_arbiter #(
  parameter  int unsigned NumReq   = 4,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] win_idx;
  logic                found;

  // Lowest-distance eligible requester measured from the pointer.
  always_comb begin : search
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned d = 0; d < NumReq; d++) begin
      if (!found && req_i[IdxWidth'((32'(ptr_q) + d) % NumReq)]) begin
        found   = 1'b1;
        win_idx = IdxWidth'((32'(ptr_q) + d) % NumReq);
      end
    end
  end

  // Grant outputs are qualified by the enable.
  always_comb begin : grant
    gnt_o   = '0;
    idx_o   = win_idx;
    valid_o = en_i && found;
    if (en_i && found) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  // Pointer moves to the requester after the winner, wrapping at NumReq.
  always_ff @(posedge clk_i) begin : ptr_reg
    if (rst_i) begin
      ptr_q <= '0;
    end else if (valid_o) begin
      ptr_q <= (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule : l2spm_rr_arbiter

// File: rtl/l2spm_arbiter.sv
// Shares the single-port L2 scratchpad SRAM among NumReq requesters with
// round-robin arbitration, one access per cycle. The winner's address is
// checked against the L2SPM window: in-window accesses go to the SRAM,
// out-of-window accesses are granted but answered with an error. Every
// grant gets exactly one response one cycle later on the winner's lane.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            request valid per requester
//   addr_i           byte address per requester
//   we_i, be_i       write enable and byte enables per requester
//   wdata_i          write data per requester
//   gnt_o            one-hot grant, same cycle as the accepted request
//   rvalid_o         response valid per requester (reads and writes)
//   err_o            address error, qualified by rvalid_o
//   rdata_o          read data, qualified by rvalid_o; unused lanes are 0
//   mem_req_o        SRAM access strobe
//   mem_gnt_i        SRAM ready; low while the macro is busy
//   mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o   SRAM access payload
//   mem_rdata_i      SRAM read data, valid the cycle after an accepted read
module l2spm_arbiter
  import l2spm_arbiter_pkg::*;
#(
  parameter  int unsigned           NumReq       = NrSlaves,
  parameter  int unsigned           AddrWidth    = L2AddrWidth,
  parameter  int unsigned           DataWidth    = L2DataWidth,
  parameter  logic [AddrWidth-1:0]  BaseAddr     = AddrWidth'(L2SPMBase),
  parameter  int unsigned           Length       = L2SPMLength,
  localparam int unsigned           BeWidth      = DataWidth / 8,
  localparam int unsigned           MemAddrWidth = $clog2(Length / BeWidth)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]                  we_i,
  input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]                  gnt_o,
  output logic [NumReq-1:0]                  rvalid_o,
  output logic [NumReq-1:0]                  err_o,
  output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic                               mem_we_o,
  output logic [BeWidth-1:0]                 mem_be_o,
  output logic [DataWidth-1:0]               mem_wdata_o,
  output logic [MemAddrWidth-1:0]            mem_addr_o,
  input  logic [DataWidth-1:0]               mem_rdata_i
);

  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned OffWidth = $clog2(BeWidth);

  // One past the last window byte, one bit wider so the compare never wraps.
  localparam logic [AddrWidth:0] WinEnd = {1'b0, BaseAddr} + (AddrWidth + 1)'(Length);

  logic                arb_en;
  logic                arb_valid;
  logic [NumReq-1:0]   arb_gnt;
  logic [IdxWidth-1:0] arb_idx;

  l2spm_req_t          win_req;
  logic [AddrWidth-1:0] win_addr;
  logic [AddrWidth-1:0] win_off;
  logic                in_range;
  logic                mem_access;

  logic                resp_valid_q;
  logic [IdxWidth-1:0] resp_idx_q;
  logic                resp_err_q;
  logic                resp_read_q;

  // No grants while the SRAM is busy or the block is in reset.
  assign arb_en = mem_gnt_i & ~rst_i;

  l2spm_rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (arb_en),
    .req_i   (req_i),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign gnt_o = arb_gnt;

  // Winner payload.
  always_comb begin : payload_sel
    win_req.addr  = L2AddrWidth'(addr_i[arb_idx]);
    win_req.we    = we_i[arb_idx];
    win_req.be    = L2BeWidth'(be_i[arb_idx]);
    win_req.wdata = L2DataWidth'(wdata_i[arb_idx]);
  end

  // Window check on the full address width.
  always_comb begin : range_check
    win_addr   = AddrWidth'(win_req.addr);
    win_off    = win_addr - BaseAddr;
    in_range   = (win_addr >= BaseAddr) && ({1'b0, win_addr} < WinEnd);
    mem_access = arb_valid && in_range;
  end

  // SRAM port; all zero unless an in-window access is granted.
  always_comb begin : mem_port
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    mem_addr_o  = '0;
    if (mem_access) begin
      mem_req_o   = 1'b1;
      mem_we_o    = win_req.we;
      mem_be_o    = BeWidth'(win_req.be);
      mem_wdata_o = DataWidth'(win_req.wdata);
      mem_addr_o  = MemAddrWidth'(win_off >> OffWidth);
    end
  end

  // Response stage: remembers who was granted and how to answer them.
  always_ff @(posedge clk_i) begin : resp_reg
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_read_q  <= 1'b0;
    end else begin
      resp_valid_q <= arb_valid;
      if (arb_valid) begin
        resp_idx_q  <= arb_idx;
        resp_err_q  <= ~in_range;
        resp_read_q <= in_range & ~win_req.we;
      end
    end
  end

  // Response demux. Gated by rst_i so a response pending when reset
  // asserts never reaches the requester.
  always_comb begin : resp_out
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (resp_valid_q && !rst_i) begin
      rvalid_o[resp_idx_q] = 1'b1;
      err_o[resp_idx_q]    = resp_err_q;
      if (resp_read_q) begin
        rdata_o[resp_idx_q] = mem_rdata_i;
      end
    end
  end

  // Structural sanity checks.
  a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_rvalid_onehot : assert property (@(posedge clk_i) $onehot0(rvalid_o));
  a_no_gnt_busy : assert property (@(posedge clk_i) !mem_gnt_i |-> (gnt_o == '0));

endmodule : l2spm_arbiter

// File: tb/tb_l2spm_arbiter.sv
// Bench for l2spm_arbiter: directed cases followed by randomized traffic.
// A behavioural model produces the expected outputs of each cycle and
// pushes them into a queue; an independent monitor pops and compares.
module tb_l2spm_arbiter;

  localparam int          N    = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] LEN  = 64'h0000_0000_0001_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][63:0]  addr;
  logic [N-1:0]        we;
  logic [N-1:0][7:0]   be;
  logic [N-1:0][63:0]  wdata;
  logic [N-1:0]        gnt;
  logic [N-1:0]        rvalid;
  logic [N-1:0]        err;
  logic [N-1:0][63:0]  rdata;
  logic                mem_req;
  logic                mem_gnt;
  logic                mem_we;
  logic [7:0]          mem_be;
  logic [63:0]         mem_wdata;
  logic [12:0]         mem_addr;
  logic [63:0]         mem_rdata;

  always #5 clk = ~clk;

  l2spm_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .err_o       (err),
    .rdata_o     (rdata),
    .mem_req_o   (mem_req),
    .mem_gnt_i   (mem_gnt),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  // Power-up content of every SRAM word; word 1 holds a known pattern.
  function automatic logic [63:0] init_word(int k);
    if (k == 1) return 64'h0000_0000_DEAD_BEEF;
    return {32'(k) ^ 32'hA5A5_0000, 32'(k) * 32'h9E37_79B9};
  endfunction

  // ---------------- SRAM macro stand-in (reacts to DUT ports) -------------
  logic [63:0] sram [int];
  logic [63:0] sram_cur;

  always @(posedge clk) begin
    if (mem_req && mem_gnt && mem_we) begin
      sram_cur = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : init_word(int'(mem_addr));
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) sram_cur[8*b +: 8] = mem_wdata[8*b +: 8];
      sram[int'(mem_addr)] = sram_cur;
    end
  end

  // Read data appears the cycle after an accepted read; garbage otherwise.
  always @(posedge clk) begin
    if (mem_req && mem_gnt && !mem_we)
      mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : init_word(int'(mem_addr));
    else
      mem_rdata <= {$urandom, $urandom};
  end

  // ---------------- reference model + scoreboard queue --------------------
  typedef struct {
    logic [N-1:0]       gnt;
    logic               mreq;
    logic               mwe;
    logic [7:0]         mbe;
    logic [63:0]        mwdata;
    logic [12:0]        maddr;
    logic [N-1:0]       rvalid;
    logic [N-1:0]       err;
    logic [N-1:0][63:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [int];
  int          ptr;
  bit          pend_v;
  int          pend_idx;
  bit          pend_err;
  logic [63:0] pend_rdata;
  int          last_win;

  // Expected outputs for the inputs currently applied; advances model state.
  task automatic model_cycle();
    exp_t        e;
    int          win;
    int          w;
    bit          inr;
    logic [63:0] a;
    logic [63:0] cur;
    e.gnt = '0; e.mreq = 1'b0; e.mwe = 1'b0; e.mbe = '0; e.mwdata = '0;
    e.maddr = '0; e.rvalid = '0; e.err = '0; e.rdata = '0;
    last_win = -1;
    if (rst) begin
      ptr    = 0;
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        e.rvalid[pend_idx] = 1'b1;
        e.err[pend_idx]    = pend_err;
        e.rdata[pend_idx]  = pend_rdata;
      end
      pend_v = 1'b0;
      if (mem_gnt) begin
        win = -1;
        for (int d = 0; d < N; d++)
          if (win < 0 && req[(ptr + d) % N]) win = (ptr + d) % N;
        if (win >= 0) begin
          last_win   = win;
          e.gnt[win] = 1'b1;
          ptr        = (win + 1) % N;
          a          = addr[win];
          inr        = (a >= BASE) && (a < BASE + LEN);
          pend_v     = 1'b1;
          pend_idx   = win;
          pend_err   = !inr;
          pend_rdata = '0;
          if (inr) begin
            w        = int'((a - BASE) / 8);
            e.mreq   = 1'b1;
            e.mwe    = we[win];
            e.mbe    = be[win];
            e.mwdata = wdata[win];
            e.maddr  = 13'(w);
            cur = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
            if (we[win]) begin
              for (int b = 0; b < 8; b++)
                if (be[win][b]) cur[8*b +: 8] = wdata[win][8*b +: 8];
              ref_mem[w] = cur;
            end else begin
              pend_rdata = cur;
            end
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ------------------------------------------------
  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_o",       64'(gnt),       64'(e.gnt));
        chk("mem_req_o",   64'(mem_req),   64'(e.mreq));
        chk("mem_we_o",    64'(mem_we),    64'(e.mwe));
        chk("mem_be_o",    64'(mem_be),    64'(e.mbe));
        chk("mem_wdata_o", mem_wdata,      e.mwdata);
        chk("mem_addr_o",  64'(mem_addr),  64'(e.maddr));
        chk("rvalid_o",    64'(rvalid),    64'(e.rvalid));
        chk("err_o",       64'(err),       64'(e.err));
        for (int i = 0; i < N; i++)
          chk($sformatf("rdata_o[%0d]", i), rdata[i], e.rdata[i]);
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic clear_reqs();
    req = '0; addr = '0; we = '0; be = '0; wdata = '0;
  endtask

  task automatic set_req(int i, logic [63:0] a, bit w, logic [7:0] b, logic [63:0] d);
    req[i] = 1'b1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
  endtask

  // Record expectations for this cycle, then move to just after the next edge.
  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom % 8)
      0:       return BASE - 64'(8 * (1 + $urandom % 2));
      1:       return BASE + LEN + 64'(8 * ($urandom % 2));
      2:       return BASE + LEN - 64'd8;
      3:       return {$urandom, $urandom};
      default: return BASE + 64'(8 * ($urandom % 32)) + 64'($urandom % 8);
    endcase
  endfunction

  // ---------------- main sequence -----------------------------------------
  initial begin : stim
    rst = 1'b1; mem_gnt = 1'b1; clear_reqs();
    ptr = 0; pend_v = 1'b0; last_win = -1;
    @(posedge clk); #1;

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single read from word 1.
    set_req(0, 64'h1C00_0008, 1'b0, 8'hFF, 64'h0);
    tick();
    clear_reqs();
    tick();

    // Full contention from ptr = 0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, BASE + 64'(8 * i), 1'b0, 8'hFF, 64'h0);
    repeat (8) tick();
    clear_reqs();
    tick();

    // Out-of-window write, above and below.
    set_req(2, 64'h1C01_0000, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    tick();
    clear_reqs();
    tick();
    set_req(2, 64'h1BFF_FFF8, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    tick();
    clear_reqs();
    tick();

    // SRAM busy: no grants, pointer holds.
    rst = 1'b1; tick(); rst = 1'b0;
    mem_gnt = 1'b0;
    set_req(0, BASE + 64'h10, 1'b0, 8'hFF, 64'h0);
    set_req(1, BASE + 64'h18, 1'b0, 8'hFF, 64'h0);
    repeat (3) tick();
    mem_gnt = 1'b1;
    tick();
    clear_reqs();
    tick();

    // Reset while a response is pending, then arbitration from ptr = 0.
    set_req(1, BASE + 64'h20, 1'b0, 8'hFF, 64'h0);
    tick();
    clear_reqs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(3, BASE + 64'h28, 1'b0, 8'hFF, 64'h0);
    set_req(0, BASE + 64'h30, 1'b0, 8'hFF, 64'h0);
    tick();
    req[0] = 1'b0;
    tick();
    clear_reqs();
    tick();

    // Partial-byte write at the top word, then read it back.
    set_req(1, 64'h1C00_FFF8, 1'b1, 8'h0F, 64'h1122_3344_5566_7788);
    tick();
    clear_reqs();
    set_req(3, 64'h1C00_FFF8, 1'b0, 8'hFF, 64'h0);
    tick();
    clear_reqs();
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (last_win >= 0) req[last_win] = 1'b0;
      rst     = ($urandom % 250) == 0;
      mem_gnt = ($urandom % 5) != 0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom % 3) == 0)
          set_req(i, rand_addr(), 1'($urandom), 8'($urandom), {$urandom, $urandom});
        else if (req[i] && ($urandom % 20) == 0)
          req[i] = 1'b0;
      end
      tick();
    end

    rst = 1'b0; mem_gnt = 1'b1; clear_reqs();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_l2spm_arbiter
